// File: rtl/alu_issue_stage.sv
// Registered issue stage feeding the 32-bit integer ALU: decodes RV32I compute
// instructions into ALU controls and holds them in a 2-entry (main + skid) buffer.
module alu_issue_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_rev,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] perf_issued
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        rev;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '0;

  entry_t dec;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] perf_q, perf_d;
  logic   acc, hs;

  // Illegal encodings still travel down the pipe with zeroed operands.
  always_comb begin
    dec     = ENTRY_ZERO;
    dec.rd  = in_rd;
    dec.ill = 1'b1;
    case (in_opcode)
      OPC_OP: begin
        if (!in_funct7b5 || in_funct3 == 3'b000 || in_funct3 == 3'b101) begin
          dec.a   = in_rs1_val;
          dec.b   = in_rs2_val;
          dec.op  = in_funct3;
          dec.rev = in_funct7b5;
          dec.ill = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (!(in_funct3 == 3'b001 && in_funct7b5)) begin
          dec.a   = in_rs1_val;
          dec.b   = in_imm;
          dec.op  = in_funct3;
          dec.rev = (in_funct3 == 3'b101) ? in_funct7b5 : 1'b0;
          dec.ill = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.b   = in_imm;
        dec.ill = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a   = in_pc;
        dec.b   = in_imm;
        dec.ill = 1'b0;
      end
      default: ;
    endcase
  end

  // Valid/ready: a beat transfers on a rising edge where valid && ready are both
  // high; in_ready is a flop (= !skid_valid) and flush drops any same-cycle accept.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    perf_d       = perf_q;
    acc          = in_valid && !skid_valid_q && !flush;
    hs           = main_valid_q && out_ready;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (hs && skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = acc;
      if (acc) skid_d = dec;
    end else if (hs || !main_valid_q) begin
      main_valid_d = acc;
      if (acc) main_d = dec;
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
    end

    if (hs && !main_q.ill && !flush) perf_d = perf_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= ENTRY_ZERO;
      skid_q       <= ENTRY_ZERO;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      perf_q       <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      perf_q       <= perf_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = main_valid_q;
  assign alu_a       = main_q.a;
  assign alu_b       = main_q.b;
  assign alu_op      = main_q.op;
  assign alu_rev     = main_q.rev;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.ill;
  assign perf_issued = perf_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_rev;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [31:0] perf_issued;

  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_pc(in_pc), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rev(alu_rev),
    .out_rd(out_rd), .out_illegal(out_illegal), .perf_issued(perf_issued)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        rev;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_perf;
  bit          m_acc;
  bit          m_hs;

  function automatic exp_t model_dec(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic f7, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] imm,
                                     input logic [31:0] pc, input logic [4:0] rd);
    exp_t e;
    e.a = 0; e.b = 0; e.op = 0; e.rev = 0; e.rd = rd; e.ill = 1;
    if (opc == 7'b0110011 && (!f7 || f3 == 0 || f3 == 5)) begin
      e.a = rs1; e.b = rs2; e.op = f3; e.rev = f7; e.ill = 0;
    end else if (opc == 7'b0010011 && !(f3 == 1 && f7)) begin
      e.a = rs1; e.b = imm; e.op = f3; e.rev = (f3 == 5) && f7; e.ill = 0;
    end else if (opc == 7'b0110111) begin
      e.b = imm; e.ill = 0;
    end else if (opc == 7'b0010111) begin
      e.a = pc; e.b = imm; e.ill = 0;
    end
    return e;
  endfunction

  // The stage is a FIFO of depth two; it accepts whenever it held fewer than two.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_perf = 0;
    end else begin
      m_acc = in_valid && (exp_q.size() < 2) && !flush;
      m_hs  = (exp_q.size() > 0) && out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_hs) begin
          if (!exp_q[0].ill) m_perf = m_perf + 1;
          void'(exp_q.pop_front());
        end
        if (m_acc)
          exp_q.push_back(model_dec(in_opcode, in_funct3, in_funct7b5, in_rs1_val,
                                    in_rs2_val, in_imm, in_pc, in_rd));
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < 2) ||
          perf_issued !== m_perf) begin
        errors++;
        $display("FAIL ctrl t=%0t: valid=%b ready=%b perf=%0d, expected valid=%b ready=%b perf=%0d",
                 $time, out_valid, in_ready, perf_issued, exp_q.size() != 0,
                 exp_q.size() < 2, m_perf);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (alu_a !== exp_q[0].a || alu_b !== exp_q[0].b || alu_op !== exp_q[0].op ||
            alu_rev !== exp_q[0].rev || out_rd !== exp_q[0].rd ||
            out_illegal !== exp_q[0].ill) begin
          errors++;
          $display("FAIL data t=%0t: a=%h b=%h op=%0d rev=%b rd=%0d ill=%b, expected a=%h b=%h op=%0d rev=%b rd=%0d ill=%b",
                   $time, alu_a, alu_b, alu_op, alu_rev, out_rd, out_illegal,
                   exp_q[0].a, exp_q[0].b, exp_q[0].op, exp_q[0].rev, exp_q[0].rd,
                   exp_q[0].ill);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    in_valid = 1; in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; in_valid = 0; in_opcode = 0; in_funct3 = 0; in_funct7b5 = 0;
    in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_pc = 0; in_rd = 0;
    flush = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_perf", perf_issued, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_ill", out_illegal, 0);
    rst_n = 1;
    @(negedge clk);

    // OP add / sub
    out_ready = 1;
    send(7'b0110011, 3'd0, 0, 32'd5, 32'd7, 0, 0, 5'd1);
    chk("op_valid", out_valid, 1);
    chk("op_a", alu_a, 5);
    chk("op_b", alu_b, 7);
    chk("op_rev0", alu_rev, 0);
    send(7'b0110011, 3'd0, 1, 32'd5, 32'd7, 0, 0, 5'd2);
    chk("op_rev1", alu_rev, 1);
    idle(1);
    chk("op_perf", perf_issued, 2);

    // OP-IMM: bit 30 ignored for addi, honoured for srai
    send(7'b0010011, 3'd0, 1, 32'd1, 32'd0, 32'hC000_0000, 0, 5'd3);
    chk("addi_rev", alu_rev, 0);
    chk("addi_b", alu_b, 32'hC000_0000);
    send(7'b0010011, 3'd5, 1, 32'd1, 32'd0, 32'd3, 0, 5'd4);
    chk("srai_op", alu_op, 5);
    chk("srai_rev", alu_rev, 1);
    chk("srai_b", alu_b, 3);

    // LUI / AUIPC
    send(7'b0110111, 3'd0, 0, 32'hDEAD, 0, 32'h1234_5000, 0, 5'd5);
    chk("lui_a", alu_a, 0);
    chk("lui_b", alu_b, 32'h1234_5000);
    send(7'b0010111, 3'd0, 0, 32'hDEAD, 0, 32'h1000, 32'h100, 5'd6);
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h1000);
    idle(1);
    chk("perf_6", perf_issued, 6);

    // Backpressure: A, B buffered, C held off, then drained in order
    out_ready = 0;
    send(7'b0110011, 3'd0, 0, 32'd11, 0, 0, 0, 5'd7);
    send(7'b0110011, 3'd0, 0, 32'd22, 0, 0, 0, 5'd8);
    chk("bp_ready0", in_ready, 0);
    chk("bp_head_a", alu_a, 11);
    send(7'b0110011, 3'd0, 0, 32'd33, 0, 0, 0, 5'd9);
    chk("bp_stable", alu_a, 11);
    out_ready = 1;
    @(negedge clk);
    chk("bp_second", alu_a, 22);
    chk("bp_ready1", in_ready, 1);
    @(negedge clk);
    chk("bp_third", alu_a, 33);
    idle(1);
    chk("perf_9", perf_issued, 9);

    // Illegal encodings
    send(7'b1100011, 3'd0, 0, 32'h55, 32'h66, 32'h77, 0, 5'd9);
    chk("br_ill", out_illegal, 1);
    chk("br_a", alu_a, 0);
    chk("br_b", alu_b, 0);
    chk("br_rd", out_rd, 9);
    send(7'b0010011, 3'd1, 1, 32'h55, 0, 32'h7, 0, 5'd10);
    chk("slli_ill", out_illegal, 1);
    idle(1);
    chk("ill_perf", perf_issued, 9);

    // Flush with two entries buffered and a same-cycle offer
    out_ready = 0;
    send(7'b0110011, 3'd0, 0, 32'd1, 0, 0, 0, 5'd11);
    send(7'b0110011, 3'd0, 0, 32'd2, 0, 0, 0, 5'd12);
    flush = 1; out_ready = 1;
    send(7'b0110011, 3'd0, 0, 32'd3, 0, 0, 0, 5'd13);
    flush = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    idle(2);
    chk("fl_perf", perf_issued, 9);

    // Randomized run, with an asynchronous reset dropped partway through
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: in_opcode = 7'b0110011;
        1: in_opcode = 7'b0010011;
        2: in_opcode = 7'b0110111;
        3: in_opcode = 7'b0010111;
        default: in_opcode = 7'($urandom_range(0, 127));
      endcase
      in_funct3   = 3'($urandom_range(0, 7));
      in_funct7b5 = 1'($urandom_range(0, 1));
      in_rs1_val  = $urandom;
      in_rs2_val  = $urandom;
      in_imm      = $urandom;
      in_pc       = $urandom;
      in_rd       = 5'($urandom_range(0, 31));
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      if (i == 1500) begin
        #3 rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_perf", perf_issued, 0);
        chk("mid_rst_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1;
      end
      @(negedge clk);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
